// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if: request, write-beat and read-response channels of the burst controller
interface ram_burst_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [WIDTH-1:0]  wr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_last;
  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rsp_ready,
    input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rsp_ready,
    output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst read/write initiator for a single-port RAM with registered read data.
// Define RAM_CTRL_INIT_EN to zero-fill the whole RAM after reset before accepting requests.
module ram_burst_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  ram_burst_ctrl_if.slave   bus,
  output logic              busy,
  output logic              ram_enable,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WIDTH-1:0]  ram_data_in,
  input  logic [WIDTH-1:0]  ram_data_out
);
  typedef enum logic [2:0] {
    IDLE, WR, RD_ISSUE, RD_CAP, RD_RESP
`ifdef RAM_CTRL_INIT_EN
    , INIT
`endif
  } state_t;
`ifdef RAM_CTRL_INIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif
  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] beats;
  logic [WIDTH-1:0]  rsp_q;
  logic              wr_fire;
  logic              init_wr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= RST_STATE;
      cur_addr <= '0;
      beats    <= '0;
      rsp_q    <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.req_valid) begin
            cur_addr <= bus.req_addr;
            beats    <= bus.req_len;
            state    <= bus.req_write ? WR : RD_ISSUE;
          end
        WR:
          if (bus.wr_valid) begin
            cur_addr <= cur_addr + 1'b1;
            beats    <= beats - 1'b1;
            if (beats == '0) state <= IDLE;
          end
        RD_ISSUE: state <= RD_CAP;
        RD_CAP: begin
          rsp_q <= ram_data_out;
          state <= RD_RESP;
        end
        RD_RESP:
          if (bus.rsp_ready) begin
            if (beats == '0) state <= IDLE;
            else begin
              cur_addr <= cur_addr + 1'b1;
              beats    <= beats - 1'b1;
              state    <= RD_ISSUE;
            end
          end
`ifdef RAM_CTRL_INIT_EN
        INIT: begin
          cur_addr <= cur_addr + 1'b1;
          if (&cur_addr) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
`ifdef RAM_CTRL_INIT_EN
  assign init_wr = state == INIT;
`else
  assign init_wr = 1'b0;
`endif
  // read_en stays high unless a write is actually being issued
  always_comb begin
    wr_fire       = state == WR && bus.wr_valid;
    bus.req_ready = state == IDLE;
    bus.wr_ready  = state == WR;
    bus.rsp_valid = state == RD_RESP;
    bus.rsp_last  = state == RD_RESP && beats == '0;
    bus.rsp_data  = rsp_q;
    busy          = state != IDLE;
    ram_enable    = wr_fire || init_wr || state == RD_ISSUE;
    ram_read_en   = !(wr_fire || init_wr);
    ram_address   = cur_addr;
    ram_data_in   = wr_fire ? bus.wr_data : '0;
  end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: randomized bench for ram_burst_ctrl against a RAM model and a reference memory image.
module tb_ram_burst_ctrl;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;
`ifdef RAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy, ram_enable, ram_read_en;
  logic [AW-1:0] ram_address;
  logic [W-1:0]  ram_data_in, ram_data_out;
  logic [W-1:0]  mem [D];
  logic [W-1:0]  ref_mem [D];
  logic [AW+W-1:0] wq [$];
  bit            filled = 1'b0;
  int            vec = 0;
  int            errs = 0;

  ram_burst_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

  ram_burst_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .ram_enable(ram_enable), .ram_read_en(ram_read_en), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // single-port RAM with registered read, plus a log of every write it receives
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < D; i++) mem[i] <= W'(i * 37 + 90);
      filled <= 1'b1;
    end else begin
      if (ram_enable && ram_read_en) ram_data_out <= mem[ram_address];
      if (ram_enable && !ram_read_en) mem[ram_address] <= ram_data_in;
      if (!rst && ram_enable && !ram_read_en) wq.push_back({ram_address, ram_data_in});
    end
  end

  task automatic reset_seq();
    int n;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wq.delete();
`ifdef RAM_CTRL_INIT_EN
    @(negedge clk);
    n = 1;
    vec++;
    if (busy !== 1'b1 || bus.req_ready !== 1'b0)
      begin errs++; $display("FAIL init_busy: busy=%b req_ready=%b want 1/0", busy, bus.req_ready); end
    while (bus.req_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    vec++;
    if (n != D + 1) begin errs++; $display("FAIL init_ready_cycle: got %0d want %0d", n, D + 1); end
    vec++;
    if (wq.size() != D) begin errs++; $display("FAIL init_write_count: got %0d want %0d", wq.size(), D); end
    else foreach (wq[i]) begin
      vec++;
      if (wq[i] !== {AW'(i), W'(0)}) begin errs++; $display("FAIL init_write: got %h want %h", wq[i], {AW'(i), W'(0)}); end
    end
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== !INIT_EN || busy !== INIT_EN || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0
        || bus.wr_ready !== 1'b0 || bus.rsp_last !== 1'b0 || ram_enable !== INIT_EN || ram_read_en !== !INIT_EN)
      begin errs++; $display("FAIL reset_hold: rr=%b busy=%b rv=%b rd=%h wr=%b rl=%b en=%b ren=%b", bus.req_ready, busy, bus.rsp_valid, bus.rsp_data, bus.wr_ready, bus.rsp_last, ram_enable, ram_read_en); end
    reset_seq();
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0 || ram_enable !== 1'b0 || ram_read_en !== 1'b1
        || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0)
      begin errs++; $display("FAIL reset_idle: rr=%b busy=%b en=%b ren=%b rv=%b rd=%h want 1 0 0 1 0 00", bus.req_ready, busy, ram_enable, ram_read_en, bus.rsp_valid, bus.rsp_data); end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d [$], input int gap_at, input int gap_n);
    int len = d.size() - 1;
    wq.delete();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_len = AW'(len);
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL wr_req_ready: got %b want 1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == gap_at) repeat (gap_n) begin
        bus.wr_valid = 1'b0;
        @(negedge clk);
        vec++;
        if (ram_enable !== 1'b0 || bus.req_ready !== 1'b0)
          begin errs++; $display("FAIL wr_gap: en=%b req_ready=%b want 0/0", ram_enable, bus.req_ready); end
        @(posedge clk); #1;
      end
      bus.wr_valid = 1'b1; bus.wr_data = d[i];
      @(negedge clk);
      vec++;
      if (bus.wr_ready !== 1'b1 || bus.req_ready !== 1'b0 || busy !== 1'b1)
        begin errs++; $display("FAIL wr_beat %0d: wr_ready=%b req_ready=%b busy=%b want 1/0/1", i, bus.wr_ready, bus.req_ready, busy); end
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0)
      begin errs++; $display("FAIL wr_done: req_ready=%b busy=%b want 1/0", bus.req_ready, busy); end
    vec++;
    if (wq.size() != len + 1) begin errs++; $display("FAIL wr_count: got %0d want %0d", wq.size(), len + 1); end
    else foreach (wq[i]) begin
      vec++;
      if (wq[i] !== {AW'(a + i), d[i]})
        begin errs++; $display("FAIL wr_ram: beat %0d got %h want %h", i, wq[i], {AW'(a + i), d[i]}); end
    end
    for (int i = 0; i <= len; i++) ref_mem[AW'(a + i)] = d[i];
  endtask

  // stall < 0 picks a random 0..3 cycle rsp_ready delay for every beat
  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] len, input int stall);
    int s, n;
    logic [W-1:0] held;
    s = stall < 0 ? int'($urandom_range(3)) : stall;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_len = len;
    bus.rsp_ready = (s == 0);
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL rd_req_ready: got %b want 1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (bus.rsp_valid !== 1'b1 && n < 12);
      vec++;
      if (n != 3) begin errs++; $display("FAIL rd_latency beat %0d: got %0d cycles want 3", i, n); end
      if (bus.rsp_valid !== 1'b1) return;
      vec++;
      if (bus.rsp_data !== ref_mem[AW'(a + i)] || bus.rsp_last !== (i == int'(len)))
        begin errs++; $display("FAIL rd_beat %0d: data=%h last=%b want %h/%b", i, bus.rsp_data, bus.rsp_last, ref_mem[AW'(a + i)], i == int'(len)); end
      held = bus.rsp_data;
      repeat (s) begin
        @(negedge clk);
        vec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || ram_enable !== 1'b0)
          begin errs++; $display("FAIL rd_stall: valid=%b data=%h en=%b want 1/%h/0", bus.rsp_valid, bus.rsp_data, ram_enable, held); end
      end
      if (s != 0) begin @(posedge clk); #1; bus.rsp_ready = 1'b1; end
      @(posedge clk); #1;
      s = stall < 0 ? int'($urandom_range(3)) : stall;
      bus.rsp_ready = (s == 0);
    end
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0)
      begin errs++; $display("FAIL rd_done: req_ready=%b busy=%b rsp_valid=%b want 1/0/0", bus.req_ready, busy, bus.rsp_valid); end
  endtask

  task automatic test_write_wrap();
    logic [W-1:0] d [$];
    d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(4'd14, d, -1, 0);
  endtask

  task automatic test_read_wrap();
    do_read(4'd14, 4'd3, 0);
  endtask

  task automatic test_read_stall();
    do_read(4'd15, 4'd0, 5);
  endtask

  task automatic test_write_gap();
    logic [W-1:0] d [$];
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_write(4'd3, d, 2, 2);
    do_read(4'd3, 4'd4, 1);
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 4'd14; bus.req_len = 4'd3; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.rsp_valid !== 1'b1 && n < 12);
    vec++;
    if (bus.rsp_valid !== 1'b1) begin errs++; $display("FAIL mid_reach_resp: rsp_valid=%b want 1", bus.rsp_valid); end
    #2 rst = 1'b1;
    #1;
    vec++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_last !== 1'b0)
      begin errs++; $display("FAIL mid_rst_valid: rsp_valid=%b rsp_last=%b want 0/0", bus.rsp_valid, bus.rsp_last); end
    reset_seq();
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0)
      begin errs++; $display("FAIL mid_idle: req_ready=%b busy=%b want 1/0", bus.req_ready, busy); end
    seen = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (6) begin @(negedge clk); seen |= bus.rsp_valid === 1'b1; end
    bus.rsp_ready = 1'b0;
    vec++;
    if (seen) begin errs++; $display("FAIL mid_no_partial: rsp_valid seen=1 want 0"); end
    do_read(4'd5, 4'd0, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] d [$];
    logic [AW-1:0] a, len;
    for (int k = 0; k < 20; k++) begin
      a = AW'($urandom);
      len = AW'($urandom_range(D - 1));
      if ($urandom_range(1) == 1) begin
        d.delete();
        for (int i = 0; i <= int'(len); i++) d.push_back(W'($urandom));
        do_write(a, d, int'($urandom_range(len + 1)), int'($urandom_range(1, 2)));
      end else do_read(a, len, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) ref_mem[i] = W'(i * 37 + 90);
    test_reset();
    test_write_wrap();
    test_read_wrap();
    test_read_stall();
    test_write_gap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
